gate_drive_guard: RTL and testbench

GATE_DRIVE_GUARD -- requirements
Module: gate_drive_guard

---
 rtl/gd_pkg.sv | 22 ++
 rtl/gd_leg.sv | 80 ++++++++
 rtl/gate_drive_guard.sv | 128 ++++++++++++
 tb/tb_gate_drive_guard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gd_pkg.sv
// Shared encodings and counter widths for the gate drive guard.
package gd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } top_state_t;

    typedef enum logic [1:0] {
        LEG_LO    = 2'd0,
        LEG_DT_LH = 2'd1,
        LEG_HI    = 2'd2,
        LEG_DT_HL = 2'd3
    } leg_state_t;

    localparam int DT_CNT_W  = 8;
    localparam int CHG_CNT_W = 16;
    localparam int FLT_CNT_W = 4;

endpackage

// File: rtl/gd_leg.sv
// Dead-time FSM for one half-bridge leg; exposes next-state gate levels so the
// top can register them together with its own state.
//   state     | meaning
//   LEG_LO    | low-side switch on
//   LEG_DT_LH | dead time, low off, waiting to turn high on
//   LEG_HI    | high-side switch on
//   LEG_DT_HL | dead time, high off, waiting to turn low on
module gd_leg
    import gd_pkg::*;
#(
    parameter int DEAD_CLKS = 12
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_pwm_q,
    output logic o_nxt_hi,
    output logic o_nxt_lo
);

    localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DEAD_CLKS - 1);

    leg_state_t          r_state, w_state_nxt;
    logic [DT_CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= LEG_LO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_clear) begin
            w_state_nxt = LEG_LO;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                LEG_LO: if (i_pwm_q) begin
                    w_state_nxt = LEG_DT_LH;
                    w_cnt_nxt   = DT_LOAD;
                end
                // A reversal aborts the dead time back to the side that was on.
                LEG_DT_LH: if (!i_pwm_q) begin
                    w_state_nxt = LEG_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = LEG_HI;
                end else begin
                    w_cnt_nxt = r_cnt - DT_CNT_W'(1);
                end
                LEG_HI: if (!i_pwm_q) begin
                    w_state_nxt = LEG_DT_HL;
                    w_cnt_nxt   = DT_LOAD;
                end
                LEG_DT_HL: if (i_pwm_q) begin
                    w_state_nxt = LEG_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = LEG_LO;
                end else begin
                    w_cnt_nxt = r_cnt - DT_CNT_W'(1);
                end
                default: begin
                    w_state_nxt = LEG_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_nxt_hi = (w_state_nxt == LEG_HI);
    assign o_nxt_lo = (w_state_nxt == LEG_LO);

endmodule

// File: rtl/gate_drive_guard.sv
// Two-leg gate driver sequencer: bootstrap pre-charge, dead-time insertion and
// filtered, latched fault shutdown. Every output is a flop.
//   state     | meaning
//   ST_IDLE   | power stage off, waiting for enable
//   ST_CHARGE | both low sides on to charge the bootstrap caps
//   ST_RUN    | legs follow PWM with dead time
//   ST_FAULT  | latched shutdown until cleared
module gate_drive_guard
    import gd_pkg::*;
#(
    parameter int DEAD_CLKS     = 12,
    parameter int CHARGE_CLKS   = 16,
    parameter int FLT_FILT_CLKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pwm_in,
    input  logic       en,
    input  logic       fault_n,
    input  logic       fault_clr,
    output logic [1:0] gate_hi,
    output logic [1:0] gate_lo,
    output logic       fault,
    output logic       ready
);

    localparam logic [CHG_CNT_W-1:0] CHG_LOAD = CHG_CNT_W'(CHARGE_CLKS - 1);
    localparam logic [FLT_CNT_W-1:0] FLT_MAX  = FLT_CNT_W'(FLT_FILT_CLKS);
    localparam logic [FLT_CNT_W-1:0] FLT_M1   = FLT_CNT_W'(FLT_FILT_CLKS - 1);

    top_state_t           r_state, w_state_nxt;
    logic [CHG_CNT_W-1:0] r_chg_cnt, w_chg_cnt_nxt;
    logic [FLT_CNT_W-1:0] r_flt_cnt, w_flt_cnt_nxt;
    logic [1:0]           r_pwm_q;
    logic                 r_sync1, r_sync2;
    logic [1:0]           r_gate_hi, r_gate_lo;
    logic                 r_fault, r_ready;
    logic                 w_trip, w_flt_act, w_leg_clear;
    logic [1:0]           w_leg_hi, w_leg_lo;

    // Trip on the edge that takes the FLT_FILT_CLKS-th consecutive low sample.
    assign w_trip    = !r_sync2 && (r_flt_cnt >= FLT_M1);
    assign w_flt_act = w_trip || (r_flt_cnt == FLT_MAX);

    always_comb begin
        w_flt_cnt_nxt = r_flt_cnt;
        if (r_sync2)
            w_flt_cnt_nxt = '0;
        else if (r_flt_cnt != FLT_MAX)
            w_flt_cnt_nxt = r_flt_cnt + FLT_CNT_W'(1);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_chg_cnt_nxt = r_chg_cnt;
        case (r_state)
            ST_IDLE: if (w_trip) begin
                w_state_nxt = ST_FAULT;
            end else if (en) begin
                w_state_nxt   = ST_CHARGE;
                w_chg_cnt_nxt = CHG_LOAD;
            end
            ST_CHARGE: if (w_trip) begin
                w_state_nxt = ST_FAULT;
            end else if (!en) begin
                w_state_nxt = ST_IDLE;
            end else if (r_chg_cnt == '0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_chg_cnt_nxt = r_chg_cnt - CHG_CNT_W'(1);
            end
            ST_RUN: if (w_trip)
                w_state_nxt = ST_FAULT;
            else if (!en)
                w_state_nxt = ST_IDLE;
            ST_FAULT: if (fault_clr && !w_flt_act)
                w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Legs sit in LO on both sides of any non-RUN interval, so RUN starts from LO.
    assign w_leg_clear = (r_state != ST_RUN) || (w_state_nxt != ST_RUN);

    for (genvar g = 0; g < 2; g++) begin : g_leg
        gd_leg #(.DEAD_CLKS(DEAD_CLKS)) u_leg (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_clear  (w_leg_clear),
            .i_pwm_q  (r_pwm_q[g]),
            .o_nxt_hi (w_leg_hi[g]),
            .o_nxt_lo (w_leg_lo[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_chg_cnt <= '0;
            r_flt_cnt <= '0;
            r_pwm_q   <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_gate_hi <= '0;
            r_gate_lo <= '0;
            r_fault   <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_chg_cnt <= w_chg_cnt_nxt;
            r_flt_cnt <= w_flt_cnt_nxt;
            r_pwm_q   <= pwm_in;
            r_sync1   <= fault_n;
            r_sync2   <= r_sync1;
            r_gate_hi <= (w_state_nxt == ST_RUN) ? w_leg_hi : 2'b00;
            r_gate_lo <= (w_state_nxt == ST_CHARGE) ? 2'b11 :
                         (w_state_nxt == ST_RUN)    ? w_leg_lo : 2'b00;
            r_fault   <= (w_state_nxt == ST_FAULT);
            r_ready   <= (w_state_nxt == ST_RUN);
        end
    end

    assign gate_hi = r_gate_hi;
    assign gate_lo = r_gate_lo;
    assign fault   = r_fault;
    assign ready   = r_ready;

endmodule

// File: tb/tb_gate_drive_guard.sv
// Directed bench for gate_drive_guard: expectations are queued per clock cycle
// as stimulus is applied and compared when that cycle's outputs settle.
module tb_gate_drive_guard;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pwm_in;
    logic       en;
    logic       fault_n;
    logic       fault_clr;
    logic [1:0] gate_hi;
    logic [1:0] gate_lo;
    logic       fault;
    logic       ready;

    gate_drive_guard #(
        .DEAD_CLKS     (12),
        .CHARGE_CLKS   (16),
        .FLT_FILT_CLKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .en        (en),
        .fault_n   (fault_n),
        .fault_clr (fault_clr),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .fault     (fault),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // {fault, ready, gate_hi[1:0], gate_lo[1:0]}
    localparam logic [5:0] V_OFF    = 6'b00_00_00;
    localparam logic [5:0] V_CHARGE = 6'b00_00_11;
    localparam logic [5:0] V_RUN    = 6'b01_00_11;
    localparam logic [5:0] V_DT0    = 6'b01_00_10;
    localparam logic [5:0] V_HI0    = 6'b01_01_10;
    localparam logic [5:0] V_DT1    = 6'b01_00_01;
    localparam logic [5:0] V_FAULT  = 6'b10_00_00;

    typedef struct {
        int         cyc;
        string      tag;
        logic [5:0] v;
    } sb_t;

    sb_t        sb[$];
    sb_t        e_cur;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic [5:0] outs;

    assign outs = {fault, ready, gate_hi, gate_lo};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_at(input int c, input string tag, input logic [5:0] v);
        sb_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic exp_range(input int c0, input int c1, input string tag, input logic [5:0] v);
        for (int c = c0; c <= c1; c++) exp_at(c, tag, v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("no_overlap", {4'b0000, gate_hi & gate_lo}, 6'b000000);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_cur = sb.pop_front();
            if (e_cur.cyc < cyc) begin
                total++;
                bad++;
                $error("FAIL %s: expectation for cyc=%0d never compared, now cyc=%0d", e_cur.tag, e_cur.cyc, cyc);
            end else begin
                check(e_cur.tag, outs, e_cur.v);
            end
        end
    end

    int c;

    initial begin
        rst       = 1'b1;
        pwm_in    = 2'b00;
        en        = 1'b0;
        fault_n   = 1'b1;
        fault_clr = 1'b0;

        tick(3);
        check("reset_outputs", outs, V_OFF);
        rst = 1'b0;
        exp_range(cyc + 1, cyc + 3, "idle_hold", V_OFF);
        tick(3);

        // Enable: 16 cycles of pre-charge, then RUN with both lows on.
        c = cyc;
        en = 1'b1;
        exp_range(c + 1, c + 16, "charge", V_CHARGE);
        exp_at(c + 17, "run_entry", V_RUN);
        tick(20);

        // Leg 0 rising command, held 100 cycles, then falling.
        c = cyc;
        pwm_in = 2'b01;
        exp_at(c + 1, "lo0_before_fall", V_RUN);
        exp_range(c + 2, c + 13, "dt_lh0", V_DT0);
        exp_at(c + 14, "hi0_rise", V_HI0);
        exp_at(c + 99, "hi0_hold", V_HI0);
        tick(100);
        c = cyc;
        pwm_in = 2'b00;
        exp_at(c + 1, "hi0_before_fall", V_HI0);
        exp_range(c + 2, c + 13, "dt_hl0", V_DT0);
        exp_at(c + 14, "lo0_rise", V_RUN);
        tick(20);

        // Leg 1 pulse shorter than the dead time: aborted back to LO.
        c = cyc;
        pwm_in = 2'b10;
        exp_at(c + 1, "lo1_before_fall", V_RUN);
        exp_range(c + 2, c + 6, "dt_lh1_short", V_DT1);
        exp_range(c + 7, c + 12, "lo1_back", V_RUN);
        tick(5);
        pwm_in = 2'b00;
        tick(15);

        // Two-cycle fault glitch is filtered out.
        c = cyc;
        fault_n = 1'b0;
        exp_range(c + 1, c + 10, "glitch_no_trip", V_RUN);
        tick(2);
        fault_n = 1'b1;
        tick(12);

        // Sustained fault trips; clear is refused while fault_n stays low.
        c = cyc;
        fault_n = 1'b0;
        exp_range(c + 1, c + 2, "pre_trip", V_RUN);
        exp_range(c + 6, c + 20, "fault_latched", V_FAULT);
        exp_at(c + 21, "idle_after_clr", V_OFF);
        exp_range(c + 22, c + 37, "recharge", V_CHARGE);
        exp_at(c + 38, "rerun", V_RUN);
        tick(8);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(1);
        fault_n = 1'b1;
        tick(10);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(20);

        // Reset mid-cycle while leg 0 is high drops the gate immediately.
        c = cyc;
        pwm_in = 2'b01;
        exp_at(c + 14, "hi0_again", V_HI0);
        tick(18);
        #2;
        check("pre_rst_hi0", outs, V_HI0);
        rst = 1'b1;
        #1;
        check("rst_async_drop", outs, V_OFF);
        pwm_in = 2'b00;
        en     = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_range(cyc + 1, cyc + 3, "idle_after_rst", V_OFF);
        tick(3);
        c = cyc;
        en = 1'b1;
        exp_range(c + 1, c + 16, "charge2", V_CHARGE);
        exp_at(c + 17, "run2", V_RUN);
        tick(20);

        // Disable during RUN returns to IDLE on the next edge.
        c = cyc;
        exp_at(c, "run_before_dis", V_RUN);
        en = 1'b0;
        exp_range(c + 1, c + 3, "idle_on_dis", V_OFF);
        tick(5);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: pending=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
